// File: rtl/axis_rr_mux_pkg.sv
// Shared AXIS beat types for axis_rr_mux: payload (TDATA+TLAST), forward (mosi) and backward (miso) channel.
package axis_rr_mux_pkg;

    localparam int AXIS_DATA_WIDTH = 40;

    typedef struct packed {
        logic                       TLAST;
        logic [AXIS_DATA_WIDTH-1:0] TDATA;
    } axis_data_t;

    typedef struct packed {
        axis_data_t data;
        logic       TVALID;
    } axis_mosi_t;

    typedef struct packed {
        logic TREADY;
    } axis_miso_t;

endpackage

// File: rtl/axis_rr_mux_arbiter.sv
// rr_arbiter: round-robin grant over a request vector; search starts after the last
// advanced grant. The pointer only moves on the advance strobe.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] last_grant;
    logic         found;
    int           c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(last_grant) + 1 + i;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = W'(c);
            end
        end
    end

    // Reset to the top index so channel 0 is the first winner.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)      last_grant <= W'(N - 1);
        else if (advance) last_grant <= grant_idx;
    end

endmodule

// File: rtl/axis_rr_mux.sv
// Round-robin AXI-Stream N:1 merger with a one-beat output register.
// Define AXIS_PACKET_LOCK_EN to hold the grant for a whole TLAST-delimited packet.
module axis_rr_mux
    import axis_rr_mux_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 8,
    parameter int SEL_WIDTH      = $clog2(CHANNEL_NUMBER)
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  axis_mosi_t [CHANNEL_NUMBER-1:0]   in_mosi_i,
    output axis_miso_t [CHANNEL_NUMBER-1:0]   in_miso_o,
    output axis_mosi_t                        out_mosi_o,
    input  axis_miso_t                        out_miso_i,
    output logic       [SEL_WIDTH-1:0]        sel_o
);

    logic [CHANNEL_NUMBER-1:0] in_valid;
    logic [CHANNEL_NUMBER-1:0] req;
    logic [CHANNEL_NUMBER-1:0] grant;
    logic [SEL_WIDTH-1:0]      g_idx;
    logic                      load_en;
    logic                      xfer;
    logic                      advance;
    axis_mosi_t                out_beat;
    logic [SEL_WIDTH-1:0]      out_sel;

    assign load_en = !out_beat.TVALID | out_miso_i.TREADY;
    assign xfer    = ARESETn & load_en & (|req);

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_ch
        assign in_valid[i]         = in_mosi_i[i].TVALID;
        assign in_miso_o[i].TREADY = grant[i] & load_en & ARESETn;
    end

`ifdef AXIS_PACKET_LOCK_EN
    logic                 locked;
    logic [SEL_WIDTH-1:0] lock_ch;

    // While mid-packet only the owning channel may request; pointer moves at packet end.
    assign req     = locked ? (in_valid & ({{(CHANNEL_NUMBER-1){1'b0}}, 1'b1} << lock_ch)) : in_valid;
    assign advance = xfer & in_mosi_i[g_idx].data.TLAST;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            locked  <= !in_mosi_i[g_idx].data.TLAST;
            lock_ch <= g_idx;
        end
    end
`else
    assign req     = in_valid;
    assign advance = xfer;
`endif

    rr_arbiter #(.N(CHANNEL_NUMBER), .W(SEL_WIDTH)) u_arb (
        .gclk      (ACLK),
        .grst_n    (ARESETn),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (g_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_beat <= '0;
            out_sel  <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_beat.data   <= in_mosi_i[g_idx].data;
                out_beat.TVALID <= 1'b1;
                out_sel         <= g_idx;
            end else begin
                out_beat.TVALID <= 1'b0;
            end
        end
    end

    assign out_mosi_o = out_beat;
    assign sel_o      = out_sel;

endmodule

// File: tb/tb_axis_rr_mux.sv
// Directed, table-driven bench for axis_rr_mux (8 channels).
module tb_axis_rr_mux;
    import axis_rr_mux_pkg::*;

    localparam int N = 8;

    logic                 ACLK = 1'b0;
    logic                 ARESETn = 1'b0;
    axis_mosi_t [N-1:0]   in_mosi;
    axis_miso_t [N-1:0]   in_miso;
    axis_mosi_t           out_mosi;
    axis_miso_t           out_miso;
    logic [2:0]           sel;
    logic [N-1:0]         tr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] vm;
        logic [7:0] lm;
        logic       rdy;
        logic [7:0] etr;
        logic       ev;
        logic [2:0] es;
    } vec_t;

    vec_t tbl[$];

    always #5 ACLK = ~ACLK;

    axis_rr_mux #(.CHANNEL_NUMBER(N)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .in_mosi_i  (in_mosi),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_miso_i (out_miso),
        .sel_o      (sel)
    );

    always_comb begin
        tr = '0;
        for (int i = 0; i < N; i++) tr[i] = in_miso[i].TREADY;
    end

    function automatic logic [AXIS_DATA_WIDTH-1:0] tdata(input int c);
        if (c == 6) return 40'hA5;
        return 40'hC0DE_0000 + 40'(c);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] vm, input logic [7:0] lm, input logic rdy);
        for (int i = 0; i < N; i++) begin
            in_mosi[i].TVALID     = vm[i];
            in_mosi[i].data.TLAST = lm[i];
            in_mosi[i].data.TDATA = tdata(i);
        end
        out_miso.TREADY = rdy;
    endtask

    // Called at a negedge: drive, check TREADY, clock, check the registered beat.
    task automatic step(input logic [7:0] vm, input logic [7:0] lm, input logic rdy,
                        input logic [7:0] etr, input logic ev, input logic [2:0] es,
                        input string nm);
        axis_data_t ed;
        drive(vm, lm, rdy);
        #1;
        chk({nm, "/tready"}, 64'(tr), 64'(etr));
        @(posedge ACLK);
        #1;
        chk({nm, "/tvalid"}, 64'(out_mosi.TVALID), 64'(ev));
        if (ev) begin
            ed.TLAST = lm[es];
            ed.TDATA = tdata(int'(es));
            chk({nm, "/sel"}, 64'(sel), 64'(es));
            chk({nm, "/data"}, 64'(out_mosi.data), 64'(ed));
        end
        @(negedge ACLK);
    endtask

    initial begin
        // all channels continuously valid: 0..7 then wrap to 0
        for (int k = 0; k < 9; k++)
            tbl.push_back('{8'hFF, 8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8)});
        // channels 2 and 5 alternate; 5 drops -> 2,2
        tbl.push_back('{8'h24, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2});
        tbl.push_back('{8'h24, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5});
        tbl.push_back('{8'h04, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2});
        tbl.push_back('{8'h04, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2});
        // 0xA5 beat from channel 6 stalled four cycles, then no-bubble handoff to 0
        tbl.push_back('{8'h40, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{8'h41, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd6});
        tbl.push_back('{8'h41, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0});
        tbl.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0});
        // empty register loads even with downstream not ready, then holds
        tbl.push_back('{8'h08, 8'hFF, 1'b0, 8'h08, 1'b1, 3'd3});
        tbl.push_back('{8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3});
        tbl.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0});

        drive(8'hFF, 8'hFF, 1'b1);
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #1;
        chk("rst/tready", 64'(tr), 64'h0);
        chk("rst/tvalid", 64'(out_mosi.TVALID), 64'h0);
        chk("rst/sel", 64'(sel), 64'h0);
        chk("rst/data", 64'(out_mosi.data), 64'h0);
        ARESETn = 1'b1;

        for (int v = 0; v < tbl.size(); v++)
            step(tbl[v].vm, tbl[v].lm, tbl[v].rdy, tbl[v].etr, tbl[v].ev, tbl[v].es,
                 $sformatf("vec%0d", v));

        // channel 1 sends a 3-beat packet while channel 3 stays valid
`ifdef AXIS_PACKET_LOCK_EN
        step(8'h0A, 8'h08, 1'b1, 8'h02, 1'b1, 3'd1, "pkt0");
        step(8'h0A, 8'h08, 1'b1, 8'h02, 1'b1, 3'd1, "pkt1");
        step(8'h0A, 8'h0A, 1'b1, 8'h02, 1'b1, 3'd1, "pkt2");
        step(8'h08, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, "pkt3");
        step(8'h08, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, "pkt4");
`else
        step(8'h0A, 8'h08, 1'b1, 8'h02, 1'b1, 3'd1, "pkt0");
        step(8'h0A, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, "pkt1");
        step(8'h0A, 8'h08, 1'b1, 8'h02, 1'b1, 3'd1, "pkt2");
        step(8'h0A, 8'h0A, 1'b1, 8'h08, 1'b1, 3'd3, "pkt3");
        step(8'h0A, 8'h0A, 1'b1, 8'h02, 1'b1, 3'd1, "pkt4");
`endif

        // reset in the middle of a packet from channel 4
        step(8'h10, 8'h00, 1'b1, 8'h10, 1'b1, 3'd4, "mid0");
        drive(8'hFF, 8'hFF, 1'b1);
        ARESETn = 1'b0;
        #1;
        chk("midrst/tvalid", 64'(out_mosi.TVALID), 64'h0);
        chk("midrst/tready", 64'(tr), 64'h0);
        chk("midrst/sel", 64'(sel), 64'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        step(8'hFF, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, "post_rst");
        step(8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, "post_rst1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
